// File: rtl/cv32e40x_fencei_flush_responder.sv
// Responder for the controller's fence.i flush handshake: blocks and drains instruction OBI,
// invalidates every icache line, then pulses ack. Optional CV32E40X_FENCEI_PERF_EN adds flush_cycles_o.
module cv32e40x_fencei_flush_responder #(
  parameter int NUM_LINES       = 16,
  parameter int MAX_OUTSTANDING = 2,
  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  localparam int CW = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef CV32E40X_FENCEI_PERF_EN
  output logic [15:0]   flush_cycles_o,
`endif
  input  logic          fencei_flush_req_i,
  output logic          fencei_flush_ack_o,
  input  logic          instr_req_i,
  input  logic          instr_gnt_i,
  input  logic          instr_rvalid_i,
  output logic          instr_block_o,
  output logic          inval_valid_o,
  output logic [IW-1:0] inval_idx_o,
  input  logic          inval_ready_i,
  output logic          busy_o
);

  typedef enum logic [2:0] {IDLE, DRAIN, INVAL, ACK, WAIT_LOW} state_e;

  localparam int LAST_IDX = (NUM_LINES > 0) ? NUM_LINES - 1 : 0;

  state_e        state;
  logic [CW-1:0] outstanding;
  logic          inc;
  logic          dec;

  assign inc = instr_req_i & instr_gnt_i;
  assign dec = instr_rvalid_i;

  // Tracks the bus even while idle so a grant in the cycle that sees req is still drained.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      if (outstanding != CW'(MAX_OUTSTANDING)) outstanding <= outstanding + 1'b1;
    end else if (dec && !inc) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      fencei_flush_ack_o <= 1'b0;
      instr_block_o      <= 1'b0;
      inval_valid_o      <= 1'b0;
      inval_idx_o        <= '0;
      busy_o             <= 1'b0;
    end else begin
      fencei_flush_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (fencei_flush_req_i) begin
            state         <= DRAIN;
            instr_block_o <= 1'b1;
            busy_o        <= 1'b1;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            if (NUM_LINES == 0) begin
              state              <= ACK;
              fencei_flush_ack_o <= 1'b1;
            end else begin
              state         <= INVAL;
              inval_valid_o <= 1'b1;
            end
          end
        end
        INVAL: begin
          // Strobe and index are held until the icache accepts; never retracted.
          if (inval_ready_i) begin
            if (inval_idx_o == IW'(LAST_IDX)) begin
              state              <= ACK;
              fencei_flush_ack_o <= 1'b1;
              inval_valid_o      <= 1'b0;
              inval_idx_o        <= '0;
            end else begin
              inval_idx_o <= inval_idx_o + 1'b1;
            end
          end
        end
        ACK: begin
          state         <= WAIT_LOW;
          instr_block_o <= 1'b0;
        end
        WAIT_LOW: begin
          // The request level from the finished flush must drop before a new one is accepted.
          if (!fencei_flush_req_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          instr_block_o <= 1'b0;
          inval_valid_o <= 1'b0;
          inval_idx_o   <= '0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

`ifdef CV32E40X_FENCEI_PERF_EN
  // Counts DRAIN entry through the ACK cycle inclusive; holds until the next flush starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cycles_o <= '0;
    end else if (state == IDLE && fencei_flush_req_i) begin
      flush_cycles_o <= 16'd1;
    end else if ((state == DRAIN || state == INVAL) && flush_cycles_o != 16'hFFFF) begin
      flush_cycles_o <= flush_cycles_o + 16'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !dec && outstanding == CW'(MAX_OUTSTANDING)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !inc && outstanding == '0));

  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DRAIN || state == INVAL) |-> fencei_flush_req_i);

endmodule

// File: tb/tb_cv32e40x_fencei_flush_responder.sv
// Directed bench for cv32e40x_fencei_flush_responder: three instances (0, 4, 16 lines) share
// the monitored bus and icache ready, each with its own flush request.
module tb_cv32e40x_fencei_flush_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_req = 1'b0, instr_gnt = 1'b0, instr_rvalid = 1'b0, inval_ready = 1'b0;
  logic req0 = 1'b0, req4 = 1'b0, req16 = 1'b0;

  logic       ack0, block0, valid0, busy0;
  logic [0:0] idx0;
  logic       ack4, block4, valid4, busy4;
  logic [1:0] idx4;
  logic       ack16, block16, valid16, busy16;
  logic [3:0] idx16;
`ifdef CV32E40X_FENCEI_PERF_EN
  logic [15:0] perf0, perf4, perf16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40x_fencei_flush_responder #(.NUM_LINES(0), .MAX_OUTSTANDING(2)) u_nl0 (
    .clk(clk), .rst_n(rst_n),
`ifdef CV32E40X_FENCEI_PERF_EN
    .flush_cycles_o(perf0),
`endif
    .fencei_flush_req_i(req0), .fencei_flush_ack_o(ack0),
    .instr_req_i(instr_req), .instr_gnt_i(instr_gnt), .instr_rvalid_i(instr_rvalid),
    .instr_block_o(block0), .inval_valid_o(valid0), .inval_idx_o(idx0),
    .inval_ready_i(inval_ready), .busy_o(busy0)
  );

  cv32e40x_fencei_flush_responder #(.NUM_LINES(4), .MAX_OUTSTANDING(2)) u_nl4 (
    .clk(clk), .rst_n(rst_n),
`ifdef CV32E40X_FENCEI_PERF_EN
    .flush_cycles_o(perf4),
`endif
    .fencei_flush_req_i(req4), .fencei_flush_ack_o(ack4),
    .instr_req_i(instr_req), .instr_gnt_i(instr_gnt), .instr_rvalid_i(instr_rvalid),
    .instr_block_o(block4), .inval_valid_o(valid4), .inval_idx_o(idx4),
    .inval_ready_i(inval_ready), .busy_o(busy4)
  );

  cv32e40x_fencei_flush_responder #(.NUM_LINES(16), .MAX_OUTSTANDING(2)) u_nl16 (
    .clk(clk), .rst_n(rst_n),
`ifdef CV32E40X_FENCEI_PERF_EN
    .flush_cycles_o(perf16),
`endif
    .fencei_flush_req_i(req16), .fencei_flush_ack_o(ack16),
    .instr_req_i(instr_req), .instr_gnt_i(instr_gnt), .instr_rvalid_i(instr_rvalid),
    .instr_block_o(block16), .inval_valid_o(valid16), .inval_idx_o(idx16),
    .inval_ready_i(inval_ready), .busy_o(busy16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic g, input logic v);
    instr_req    = r;
    instr_gnt    = g;
    instr_rvalid = v;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({ack0, block0, valid0, idx0, busy0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_nl0 got=%b exp=0", {ack0, block0, valid0, idx0, busy0});
    end
    checks++;
    if ({ack4, block4, valid4, idx4, busy4} !== 6'b0) begin
      errors++;
      $display("FAIL reset_nl4 got=%b exp=0", {ack4, block4, valid4, idx4, busy4});
    end
    checks++;
    if ({ack16, block16, valid16, idx16, busy16} !== 8'b0) begin
      errors++;
      $display("FAIL reset_nl16 got=%b exp=0", {ack16, block16, valid16, idx16, busy16});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // NUM_LINES=0, idle bus: ack only at cycle 2, block in cycles 1-2, then WAIT_LOW.
  task automatic test_basic_nl0();
    req0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({ack0, block0} !== {1'(c == 2), 1'(c == 1 || c == 2)}) begin
        errors++;
        $display("FAIL basic_c%0d ack/block got=%b exp=%b", c, {ack0, block0},
                 {1'(c == 2), 1'(c == 1 || c == 2)});
      end
      tick();
    end
    tick();
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL wait_low_busy got=%b exp=1", busy0);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_req_low busy got=%b exp=0", busy0);
    end
  endtask

  // Two outstanding before the request; rvalids at +3 and +5; ack at +7.
  task automatic test_drain();
    bus(1, 1, 0);
    tick();
    bus(1, 1, 0);
    tick();
    bus(0, 0, 0);
    req0 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus(0, 0, 1'(c == 3 || c == 5));
      checks++;
      if ({ack0, block0} !== {1'(c == 7), 1'(c >= 1 && c <= 7)}) begin
        errors++;
        $display("FAIL drain_c%0d ack/block got=%b exp=%b", c, {ack0, block0},
                 {1'(c == 7), 1'(c >= 1 && c <= 7)});
      end
      tick();
    end
    bus(0, 0, 0);
    req0 = 1'b0;
    tick();
    tick();
  endtask

  // A grant in the IDLE cycle that sees req is counted and must be drained.
  task automatic test_idle_cycle_grant();
    req0 = 1'b1;
    bus(1, 1, 0);
    tick();
    bus(0, 0, 1);
    tick();
    bus(0, 0, 0);
    checks++;
    if ({ack0, block0} !== 2'b01) begin
      errors++;
      $display("FAIL idle_grant_still_drain got=%b exp=01", {ack0, block0});
    end
    tick();
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL idle_grant_ack got=%b exp=1", ack0);
    end
    tick();
    req0 = 1'b0;
    tick();
    tick();
  endtask

  // count=1, simultaneous req&gnt and rvalid keeps count at 1, so DRAIN holds.
  task automatic test_simultaneous();
    bus(1, 1, 0);
    tick();
    bus(0, 0, 0);
    req0 = 1'b1;
    tick();
    bus(1, 1, 1);
    tick();
    bus(0, 0, 0);
    tick();
    checks++;
    if ({ack0, block0} !== 2'b01) begin
      errors++;
      $display("FAIL simul_hold_drain got=%b exp=01", {ack0, block0});
    end
    bus(0, 0, 1);
    tick();
    bus(0, 0, 0);
    checks++;
    if (ack0 !== 1'b0) begin
      errors++;
      $display("FAIL simul_early_ack got=%b exp=0", ack0);
    end
    tick();
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL simul_ack got=%b exp=1", ack0);
    end
    tick();
    req0 = 1'b0;
    tick();
    tick();
  endtask

  // NUM_LINES=4 with ready low for 3 cycles on index 2.
  task automatic test_inval_stall();
    logic [1:0] exp_idx [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    logic       rdy     [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    req4 = 1'b1;
    inval_ready = 1'b1;
    tick();
    checks++;
    if ({valid4, block4} !== 2'b01) begin
      errors++;
      $display("FAIL stall_drain valid/block got=%b exp=01", {valid4, block4});
    end
    tick();
    for (int i = 0; i < 7; i++) begin
      inval_ready = rdy[i];
      checks++;
      if ({valid4, idx4, ack4} !== {1'b1, exp_idx[i], 1'b0}) begin
        errors++;
        $display("FAIL stall_step%0d valid/idx/ack got=%b exp=%b", i, {valid4, idx4, ack4},
                 {1'b1, exp_idx[i], 1'b0});
      end
      tick();
    end
    checks++;
    if ({ack4, valid4, idx4, block4} !== 5'b10001) begin
      errors++;
      $display("FAIL stall_ack got=%b exp=10001", {ack4, valid4, idx4, block4});
    end
    tick();
    checks++;
    if ({ack4, block4} !== 2'b00) begin
      errors++;
      $display("FAIL stall_ack_pulse got=%b exp=00", {ack4, block4});
    end
    req4 = 1'b0;
    tick();
    tick();
  endtask

  // Reset asserted while NUM_LINES=16 instance is invalidating index 5.
  task automatic test_reset_mid_flush();
    inval_ready = 1'b1;
    req16 = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if ({valid16, idx16} !== 5'b10101) begin
      errors++;
      $display("FAIL midflush_idx5 got=%b exp=10101", {valid16, idx16});
    end
    #2;
    rst_n = 1'b0;
    req16 = 1'b0;
    #1;
    checks++;
    if ({ack16, block16, valid16, idx16, busy16} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=0", {ack16, block16, valid16, idx16, busy16});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({ack16, busy16, block16} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_c%0d ack/busy/block got=%b exp=000", c,
                 {ack16, busy16, block16});
      end
    end
  endtask

`ifdef CV32E40X_FENCEI_PERF_EN
  task automatic test_perf();
    inval_ready = 1'b1;
    req4 = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if ({ack4, perf4} !== {1'b1, 16'd6}) begin
      errors++;
      $display("FAIL perf_at_ack ack=%b cycles=%0d exp ack=1 cycles=6", ack4, perf4);
    end
    tick();
    req4 = 1'b0;
    tick();
    tick();
    checks++;
    if (perf4 !== 16'd6) begin
      errors++;
      $display("FAIL perf_hold got=%0d exp=6", perf4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_nl0();
    test_drain();
    test_idle_cycle_grant();
    test_simultaneous();
    test_inval_stall();
    test_reset_mid_flush();
`ifdef CV32E40X_FENCEI_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
